// File: rtl/fsquare_seq.sv
// Sequential binary32 squaring unit: shift-add mantissa multiply, then one
// normalize/round/pack cycle, with valid/ready handshakes on both sides.
module fsquare_seq #(
    parameter int STEP = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int NCYC = 24 / STEP;

    typedef enum logic [1:0] {IDLE, MUL, NORM, OUT} state_t;
    typedef enum logic [1:0] {C_NORMAL, C_NAN, C_INF, C_ZERO} cls_t;

    state_t      state_reg, state_next;
    cls_t        cls_reg, cls_next;
    logic [47:0] acc_reg, acc_next;
    logic [47:0] mcand_reg, mcand_next;
    logic [23:0] mplier_reg, mplier_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [7:0]  exp_reg, exp_next;
    logic [31:0] y_reg, y_next;

    // One partial product per multiplier bit consumed this cycle.
    logic [47:0] pp [STEP];
    logic [47:0] step_sum;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
            assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : 48'd0;
        end
    endgenerate

    always_comb begin
        step_sum = 48'd0;
        for (int i = 0; i < STEP; i++) begin
            step_sum = step_sum + pp[i];
        end
    end

    logic               hi, guard, sticky, round_up;
    logic [22:0]        mant;
    logic [23:0]        mant_r;
    logic signed [10:0] exp_w, exp_f;
    logic [31:0]        packed_y;

    always_comb begin
        hi       = acc_reg[47];
        mant     = hi ? acc_reg[46:24] : acc_reg[45:23];
        guard    = hi ? acc_reg[23] : acc_reg[22];
        sticky   = hi ? |acc_reg[22:0] : |acc_reg[21:0];
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {23'd0, round_up};
        exp_w    = signed'({2'b00, exp_reg, 1'b0}) - (hi ? 11'sd126 : 11'sd127);
        exp_f    = exp_w + signed'({10'd0, mant_r[23]});
        packed_y = 32'h0000_0000;
        case (cls_reg)
            C_NAN:   packed_y = 32'h7FC0_0000;
            C_INF:   packed_y = 32'h7F80_0000;
            C_ZERO:  packed_y = 32'h0000_0000;
            default: begin
                if (exp_f >= 11'sd255)
                    packed_y = 32'h7F80_0000;
                else if (exp_f <= 11'sd0)
                    packed_y = 32'h0000_0000;
                else
                    packed_y = {1'b0, exp_f[7:0], mant_r[22:0]};
            end
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        cls_next    = cls_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        cnt_next    = cnt_reg;
        exp_next    = exp_reg;
        y_next      = y_reg;
        in_ready    = (state_reg == IDLE);
        out_valid   = (state_reg == OUT);
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    // Specials still run the full multiply so latency is fixed.
                    mcand_next  = {24'd0, 1'b1, x[22:0]};
                    mplier_next = {1'b1, x[22:0]};
                    acc_next    = 48'd0;
                    cnt_next    = 5'd0;
                    exp_next    = x[30:23];
                    if (x[30:23] == 8'hFF && x[22:0] != 23'd0)
                        cls_next = C_NAN;
                    else if (x[30:23] == 8'hFF)
                        cls_next = C_INF;
                    else if (x[30:23] == 8'h00)
                        cls_next = C_ZERO;
                    else
                        cls_next = C_NORMAL;
                    state_next = MUL;
                end
            end
            MUL: begin
                acc_next    = acc_reg + step_sum;
                mcand_next  = mcand_reg << STEP;
                mplier_next = mplier_reg >> STEP;
                cnt_next    = cnt_reg + 5'd1;
                if (cnt_reg == 5'(NCYC - 1))
                    state_next = NORM;
            end
            NORM: begin
                y_next     = packed_y;
                state_next = OUT;
            end
            OUT: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            cls_reg    <= C_NORMAL;
            acc_reg    <= 48'd0;
            mcand_reg  <= 48'd0;
            mplier_reg <= 24'd0;
            cnt_reg    <= 5'd0;
            exp_reg    <= 8'd0;
            y_reg      <= 32'd0;
        end else begin
            state_reg  <= state_next;
            cls_reg    <= cls_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_next;
            exp_reg    <= exp_next;
            y_reg      <= y_next;
        end
    end

    assign y = y_reg;
endmodule

// File: tb/tb_fsquare_seq.sv
// Directed-vector bench for fsquare_seq: runs STEP=1 and STEP=4 instances in
// lockstep, checks results, latency, backpressure and mid-operation reset.
module tb_fsquare_seq;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] xin = 32'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ir1, ov1, ir4, ov4;
    logic [31:0] y1, y4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fsquare_seq #(.STEP(1)) dut1 (
        .clk(clk), .rstn(rstn), .x(xin), .in_valid(in_valid), .in_ready(ir1),
        .y(y1), .out_valid(ov1), .out_ready(out_ready)
    );

    fsquare_seq #(.STEP(4)) dut4 (
        .clk(clk), .rstn(rstn), .x(xin), .in_valid(in_valid), .in_ready(ir4),
        .y(y4), .out_valid(ov4), .out_ready(out_ready)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference: square in double precision (exact), then round to single.
    function automatic logic [31:0] ref_sq(input logic [31:0] xv);
        logic [63:0] d, q;
        real         r;
        int          e;
        logic [22:0] m;
        logic        g, s;
        logic [23:0] mm;
        d  = {1'b0, 11'(int'(xv[30:23]) - 127 + 1023), xv[22:0], 29'd0};
        r  = $bitstoreal(d);
        r  = r * r;
        q  = $realtobits(r);
        e  = int'(q[62:52]) - 1023 + 127;
        m  = q[51:29];
        g  = q[28];
        s  = |q[27:0];
        mm = {1'b0, m} + {23'd0, (g && (s || m[0]))};
        if (mm[23]) e++;
        return {1'b0, 8'(e), mm[22:0]};
    endfunction

    // Issue one operand to both units, wait (bounded) for both results, then handshake.
    task automatic run_op(input logic [31:0] xv, output logic [31:0] r1, output logic [31:0] r4,
                          output int l1, output int l4);
        xin = xv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l1 = -1; l4 = -1; r1 = 32'hDEAD_BEEF; r4 = 32'hDEAD_BEEF;
        for (int cyc = 1; cyc <= 40 && (l1 < 0 || l4 < 0); cyc++) begin
            @(posedge clk); #1;
            if (ov1 && l1 < 0) begin l1 = cyc; r1 = y1; end
            if (ov4 && l4 < 0) begin l4 = cyc; r4 = y4; end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("x=%h y1=%h (lat %0d) y4=%h (lat %0d)", xv, r1, l1, r4, l4);
    endtask

    initial begin
        logic [31:0] r1, r4, rx, hold_y;
        int          l1, l4;

        vt[0]  = '{32'h3F80_0000, 32'h3F80_0000};
        vt[1]  = '{32'h4040_0000, 32'h4110_0000};
        vt[2]  = '{32'hC000_0000, 32'h4080_0000};
        vt[3]  = '{32'h3FC0_0000, 32'h4010_0000};
        vt[4]  = '{32'h3F80_0001, 32'h3F80_0002};
        vt[5]  = '{32'h3FB5_04F3, 32'h3FFF_FFFF};
        vt[6]  = '{32'h5F80_0000, 32'h7F80_0000};
        vt[7]  = '{32'h1F80_0000, 32'h0000_0000};
        vt[8]  = '{32'h7FC0_0001, 32'h7FC0_0000};
        vt[9]  = '{32'h0000_0005, 32'h0000_0000};
        vt[10] = '{32'hFF80_0000, 32'h7F80_0000};
        vt[11] = '{32'h2000_0000, 32'h0080_0000};
        vt[12] = '{32'h5F7F_FFFF, 32'h7F7F_FFFE};
        vt[13] = '{32'h3FB5_04F4, 32'h4000_0001};

        #12;
        check("reset_in_ready", {31'd0, ir1}, 32'd1);
        check("reset_out_valid", {31'd0, ov1}, 32'd0);
        check("reset_y", y1, 32'd0);
        check("reset_out_valid4", {31'd0, ov4}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].x, r1, r4, l1, l4);
            check($sformatf("vec%0d_y_step1", i), r1, vt[i].y);
            check($sformatf("vec%0d_y_step4", i), r4, vt[i].y);
            check($sformatf("vec%0d_lat_step1", i), 32'(l1), 32'd25);
            check($sformatf("vec%0d_lat_step4", i), 32'(l4), 32'd7);
        end
        check("sqrt2_model", vt[5].y, ref_sq(32'h3FB5_04F3));

        // Backpressure, with in_valid pulses during MUL that must be ignored.
        xin = 32'h3FC0_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l1 = -1;
        for (int cyc = 1; cyc <= 40 && l1 < 0; cyc++) begin
            if (cyc >= 2 && cyc <= 5) begin
                xin = 32'h4040_0000;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (cyc == 3) check("bp_in_ready_mul", {31'd0, ir1}, 32'd0);
            if (ov1) l1 = cyc;
        end
        in_valid = 1'b0;
        check("bp_latency", 32'(l1), 32'd25);
        hold_y = y1;
        check("bp_first_y", hold_y, 32'h4010_0000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), {31'd0, ov1}, 32'd1);
            check($sformatf("bp_hold%0d_y", k), y1, hold_y);
            check($sformatf("bp_hold%0d_in_ready", k), {31'd0, ir1}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", {31'd0, ir1}, 32'd1);
        check("bp_out_valid_after", {31'd0, ov1}, 32'd0);
        $display("backpressure sequence x=3fc00000 y=%h", hold_y);

        // Reset mid-MUL: abort, then a clean operation afterwards.
        xin = 32'h4040_0000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, ov1}, 32'd0);
        check("rst_in_ready", {31'd0, ir1}, 32'd1);
        check("rst_y", y1, 32'd0);
        check("rst_out_valid4", {31'd0, ov4}, 32'd0);
        check("rst_y4", y4, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (ov1) check("rst_no_result", {31'd0, ov1}, 32'd0);
        end
        $display("reset-abort sequence done");
        run_op(32'h4040_0000, r1, r4, l1, l4);
        check("post_rst_y", r1, 32'h4110_0000);
        check("post_rst_lat", 32'(l1), 32'd25);

        // Random positive normals whose squares stay in the normal range.
        for (int i = 0; i < 300; i++) begin
            rx = {1'b0, 8'($urandom_range(180, 70)), 23'($urandom)};
            run_op(rx, r1, r4, l1, l4);
            check($sformatf("rand%0d_step1", i), r1, ref_sq(rx));
            check($sformatf("rand%0d_step4", i), r4, ref_sq(rx));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
